// File: rtl/tpu_result_drain_pkg.sv
// Shared widths, FIFO depth and FSM state encoding for the TPU result-drain block.
package tpu_result_drain_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int WORD_WIDTH = 256;
    localparam int FIFO_D     = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/tpu_result_drain_if.sv
// Valid/ready row stream from the result drain toward the PS-side DMA.
interface tpu_result_drain_if
    import tpu_result_drain_pkg::*;
#(
    parameter int WORD_W = WORD_WIDTH
);
    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tpu_fifo2.sv
// Two-entry synchronous FIFO; a push into a full FIFO is honoured when a pop happens in the same cycle.
module tpu_fifo2 #(
    parameter int WIDTH = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: state and storage use non-blocking assignments so every reader in this
    // clock edge sees pre-edge values; the two entries are reset because the stream
    // data output must read 0 out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign dout  = mem[rd_ptr];
endmodule

// File: rtl/tpu_result_drain.sv
// Reads result rows P[base..base+rows-1] from the P global buffer and streams them out
// on a valid/ready interface, never dropping or duplicating a row under backpressure.
module tpu_result_drain
    import tpu_result_drain_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int WORD_W = WORD_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] rows_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              enp_o,
    output logic              wep_o,
    output logic [ADDR_W-1:0] addrp_o,
    input  logic [WORD_W-1:0] wordp_i,
    tpu_result_drain_if.master m_axis
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    drain_state_e      state;
    logic [ADDR_W-1:0] rows_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] issued_q;
    logic [ADDR_W-1:0] accepted_q;
    logic              rd_pending_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              room;

    tpu_fifo2 #(.WIDTH(WORD_W)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rd_pending_q),
        .din   (wordp_i),
        .pop   (pop),
        .dout  (m_axis.tdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop = ~fifo_empty & m_axis.tready;

    // occupancy - pop + inflight < FIFO_D, spelled out on the flags: crediting this
    // cycle's pop is what lets a read issue every cycle with ready held high.
    assign room = fifo_empty
                | (~rd_pending_q & (pop | ~fifo_full))
                | (pop & ~fifo_full);

    assign enp_o   = (state == S_READ) & room;
    assign wep_o   = 1'b0;
    assign addrp_o = enp_o ? addr_q : last_addr_q;

    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tlast  = ~fifo_empty & (accepted_q == rows_q - ADDR_ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            rows_q       <= '0;
            addr_q       <= '0;
            last_addr_q  <= '0;
            issued_q     <= '0;
            accepted_q   <= '0;
            rd_pending_q <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            rd_pending_q <= enp_o;
            done_o       <= 1'b0;

            if (enp_o) begin
                last_addr_q <= addr_q;
                addr_q      <= addr_q + ADDR_ONE;
                issued_q    <= issued_q + ADDR_ONE;
            end
            if (pop) begin
                accepted_q <= accepted_q + ADDR_ONE;
            end

            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rows_q     <= rows_i;
                        addr_q     <= base_addr_i;
                        issued_q   <= '0;
                        accepted_q <= '0;
                        if (rows_i != '0) begin
                            state  <= S_READ;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (enp_o && (issued_q == rows_q - ADDR_ONE)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && m_axis.tlast) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed-plus-random bench for tpu_result_drain: a P-buffer memory model feeds reads and a
// monitor logs reads, beats and done pulses, which are compared against the expected row list.
module tb_tpu_result_drain;
    import tpu_result_drain_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int WW = WORD_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] rows_in;
    logic          busy;
    logic          done;
    logic          enp;
    logic          wep;
    logic [AW-1:0] addrp;
    logic [WW-1:0] wordp;

    tpu_result_drain_if #(.WORD_W(WW)) m_axis ();

    tpu_result_drain #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr),
        .rows_i      (rows_in),
        .busy_o      (busy),
        .done_o      (done),
        .enp_o       (enp),
        .wep_o       (wep),
        .addrp_o     (addrp),
        .wordp_i     (wordp),
        .m_axis      (m_axis.master)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // P global buffer: read data appears the cycle after the enable.
    logic [WW-1:0] mem [DEPTH];
    always @(posedge clk_i) begin
        if (enp) wordp <= mem[addrp];
        else     wordp <= {8{32'hBAD0_F00D}};
    end

    // Observation logs, all cycles relative to the start pulse of the current run.
    int            c0 = 0;
    int            enp_cyc[$];
    logic [AW-1:0] enp_addr[$];
    int            beat_cyc[$];
    logic [WW-1:0] beat_data[$];
    logic          beat_last[$];
    int            done_cyc[$];
    int            n_issued, n_accepted, n_valid, max_out, stall_viol, wep_seen;
    logic          stalled = 1'b0;
    logic [WW-1:0] held_data;
    logic          held_last;

    always @(negedge clk_i) begin
        if (rst_i !== 1'b1) begin
            if (enp) begin
                enp_cyc.push_back(cyc - c0);
                enp_addr.push_back(addrp);
                n_issued++;
            end
            if (m_axis.tvalid && m_axis.tready) begin
                beat_cyc.push_back(cyc - c0);
                beat_data.push_back(m_axis.tdata);
                beat_last.push_back(m_axis.tlast);
                n_accepted++;
            end
            if (m_axis.tvalid) n_valid++;
            if (done) done_cyc.push_back(cyc - c0);
            if (wep !== 1'b0) wep_seen++;
            if (n_issued - n_accepted > max_out) max_out = n_issued - n_accepted;
            if (stalled && (m_axis.tvalid !== 1'b1 || m_axis.tdata !== held_data ||
                            m_axis.tlast !== held_last))
                stall_viol++;
            stalled   = m_axis.tvalid && !m_axis.tready;
            held_data = m_axis.tdata;
            held_last = m_axis.tlast;
        end else begin
            stalled = 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clear_logs();
        enp_cyc.delete();
        enp_addr.delete();
        beat_cyc.delete();
        beat_data.delete();
        beat_last.delete();
        done_cyc.delete();
        n_issued   = 0;
        n_accepted = 0;
        n_valid    = 0;
        max_out    = 0;
        stall_viol = 0;
        wep_seen   = 0;
    endtask

    task automatic set_ready(input int mode, input int r);
        case (mode)
            0:       m_axis.tready = 1'b1;
            1:       m_axis.tready = (r % 2 == 1);
            default: m_axis.tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One drain: pulse start, drive ready per mode, optionally re-pulse start at restart_rel,
    // then compare what was read and streamed against the rows the request asked for.
    task automatic run(input logic [AW-1:0] base, input int rows, input int mode,
                       input int restart_rel);
        int limit;
        int a;
        limit = rows * 4 + 40;
        clear_logs();
        base_addr = base;
        rows_in   = AW'(rows);
        start_i   = 1'b1;
        c0        = cyc;
        set_ready(mode, 0);
        step();
        start_i = 1'b0;
        for (int r = 1; r <= limit && done_cyc.size() == 0; r++) begin
            if (r == restart_rel) begin
                start_i   = 1'b1;
                base_addr = '0;
                rows_in   = AW'(5);
            end else begin
                start_i = 1'b0;
            end
            set_ready(mode, r);
            if (r == 1 && rows != 0) check("busy_after_start", WW'(busy), WW'(1));
            step();
        end
        start_i       = 1'b0;
        m_axis.tready = 1'b1;
        check("done_seen", WW'(done_cyc.size() > 0), WW'(1));
        step();
        step();
        check("done_single_pulse", WW'(done_cyc.size()), WW'(1));
        check("busy_idle_after_done", WW'(busy), WW'(0));
        check("rows_streamed", WW'(beat_data.size()), WW'(rows));
        check("reads_issued", WW'(enp_addr.size()), WW'(rows));
        for (int i = 0; i < rows && i < beat_data.size(); i++) begin
            a = (int'(base) + i) % DEPTH;
            check($sformatf("beat_data[%0d]", i), beat_data[i], mem[a]);
            check($sformatf("beat_last[%0d]", i), WW'(beat_last[i]), WW'(i == rows - 1));
        end
        for (int i = 0; i < rows && i < enp_addr.size(); i++) begin
            a = (int'(base) + i) % DEPTH;
            check($sformatf("read_addr[%0d]", i), WW'(enp_addr[i]), WW'(a));
        end
        check("inflight_plus_occupancy_le_2", WW'(max_out <= FIFO_D), WW'(1));
        check("stable_while_stalled", WW'(stall_viol), WW'(0));
        check("wep_never_high", WW'(wep_seen), WW'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, WW'(m_axis.tvalid), WW'(0));
        check({tag, "_tlast"},  WW'(m_axis.tlast),  WW'(0));
        check({tag, "_tdata"},  m_axis.tdata,       WW'(0));
        check({tag, "_enp"},    WW'(enp),           WW'(0));
        check({tag, "_wep"},    WW'(wep),           WW'(0));
        check({tag, "_addrp"},  WW'(addrp),         WW'(0));
        check({tag, "_busy"},   WW'(busy),          WW'(0));
        check({tag, "_done"},   WW'(done),          WW'(0));
    endtask

    initial begin
        rst_i         = 1'b1;
        start_i       = 1'b0;
        base_addr     = '0;
        rows_in       = '0;
        m_axis.tready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        repeat (3) step();
        check_outputs_zero("reset");
        rst_i = 1'b0;
        repeat (2) step();

        // Full-rate drain with ready held high: fixed latency from the start pulse.
        run(AW'('h200), 10, 0, -1);
        check("t1_first_enp_cycle",  WW'(enp_cyc[0]),                WW'(1));
        check("t1_last_enp_cycle",   WW'(enp_cyc[enp_cyc.size()-1]), WW'(10));
        check("t1_first_beat_cycle", WW'(beat_cyc[0]),               WW'(3));
        check("t1_last_beat_cycle",  WW'(beat_cyc[beat_cyc.size()-1]), WW'(12));
        check("t1_done_cycle",       WW'(done_cyc[0]),               WW'(13));

        // Ready toggling 1010...
        run(AW'('h200), 10, 1, -1);

        // Empty request: no reads, no beats, done on the next cycle.
        run(AW'('h000), 0, 0, -1);
        check("t3_done_cycle", WW'(done_cyc[0]), WW'(1));
        check("t3_no_tvalid",  WW'(n_valid),     WW'(0));

        // Address wrap at the top of the buffer.
        run(AW'('hFFE), 4, 2, -1);

        // A second start during READ is ignored; a later one in IDLE starts a new drain.
        run(AW'('h100), 10, 0, 3);
        run(AW'('h300), 6, 2, -1);

        // Reset while the 5th beat is stalled, then a fresh 3-row drain.
        clear_logs();
        base_addr     = AW'('h080);
        rows_in       = AW'(10);
        m_axis.tready = 1'b1;
        start_i       = 1'b1;
        c0            = cyc;
        step();
        start_i = 1'b0;
        for (int r = 0; r < 40 && n_accepted < 4; r++) step();
        m_axis.tready = 1'b0;
        #1;
        check("t6_accepted_before_rst", WW'(n_accepted),    WW'(4));
        check("t6_valid_before_rst",    WW'(m_axis.tvalid), WW'(1));
        rst_i = 1'b1;
        #1;
        check_outputs_zero("t6_async_rst");
        repeat (2) step();
        rst_i = 1'b0;
        step();
        run(AW'('h050), 3, 0, -1);

        // Random drains with random backpressure.
        for (int k = 0; k < 4; k++)
            run(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
